// File: rtl/bram_access_arbiter_if.sv
// rtl/bram_access_arbiter_if.sv - requester, memory and status signals of the BRAM access arbiter
//
// Bundles both requester ports (r0_*, r1_*), the single-port BRAM command/response
// signals (mem_*) and the status outputs (rd_err, busy).
//   slave  : the arbiter side (receives requests and read data, drives grants, BRAM commands, status)
//   master : the environment side (requesters plus BRAM)
interface bram_access_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
);
  logic                  r0_req;
  logic                  r0_wen;
  logic [ADDR_WIDTH-1:0] r0_addr;
  logic [DATA_WIDTH-1:0] r0_wdata;
  logic                  r0_gnt;
  logic [DATA_WIDTH-1:0] r0_rdata;
  logic                  r0_rvalid;

  logic                  r1_req;
  logic                  r1_wen;
  logic [ADDR_WIDTH-1:0] r1_addr;
  logic [DATA_WIDTH-1:0] r1_wdata;
  logic                  r1_gnt;
  logic [DATA_WIDTH-1:0] r1_rdata;
  logic                  r1_rvalid;

  logic                  mem_wen;
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;

  logic                  rd_err;
  logic                  busy;

  modport slave (
    input  r0_req, r0_wen, r0_addr, r0_wdata,
    output r0_gnt, r0_rdata, r0_rvalid,
    input  r1_req, r1_wen, r1_addr, r1_wdata,
    output r1_gnt, r1_rdata, r1_rvalid,
    output mem_wen, mem_ren, mem_addr, mem_wdata,
    input  mem_rdata, mem_rvalid,
    output rd_err, busy
  );

  modport master (
    output r0_req, r0_wen, r0_addr, r0_wdata,
    input  r0_gnt, r0_rdata, r0_rvalid,
    output r1_req, r1_wen, r1_addr, r1_wdata,
    input  r1_gnt, r1_rdata, r1_rvalid,
    input  mem_wen, mem_ren, mem_addr, mem_wdata,
    output mem_rdata, mem_rvalid,
    input  rd_err, busy
  );
endinterface

// File: rtl/bram_access_arbiter.sv
// rtl/bram_access_arbiter.sv - two-port sequencer sharing one single-port BRAM
//
// Serves one access at a time: IDLE picks a winner, ISSUE drives the BRAM command
// for exactly one cycle with a grant pulse, WAIT_RD waits for mem_rvalid (or a
// timeout) and returns the read data to the owner with a one-cycle rvalid pulse.
// Ports:
//   clk   : system clock
//   rstn  : asynchronous active-low reset
//   bus   : bram_access_arbiter_if.slave (r0_*/r1_* requesters, mem_* BRAM, rd_err, busy)
// Every output is a flop; the next value is computed in the combinational process.
module bram_access_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int RR_MODE    = 1,
  parameter int RD_TIMEOUT = 15
) (
  input logic                  clk,
  input logic                  rstn,
  bram_access_arbiter_if.slave bus
);

  localparam int CW = $clog2(RD_TIMEOUT + 1);
  localparam logic [CW-1:0] TMO = CW'(RD_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD} state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_q, last_d;     // port served most recently
  logic [CW-1:0]         cnt_q, cnt_d;

  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic                  mem_wen_q, mem_wen_d;
  logic                  mem_ren_q, mem_ren_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  rd_err_q, rd_err_d;
  logic                  busy_q, busy_d;

  logic                  win;

  // Winner when at least one port requests: a lone requester wins outright;
  // on contention round-robin favours the port not served last, fixed mode port 0.
  always_comb begin
    win = 1'b0;
    if (bus.r0_req && bus.r1_req) begin
      win = (RR_MODE != 0) ? ~last_q : 1'b0;
    end else begin
      win = bus.r1_req;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    gnt_d       = 2'b00;
    rvalid_d    = 2'b00;
    rd_err_d    = 1'b0;
    mem_wen_d   = 1'b0;
    mem_ren_d   = 1'b0;
    // Address/data flops double as the captured command; they simply hold.
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    case (state_q)
      S_IDLE: begin
        if (bus.r0_req || bus.r1_req) begin
          owner_d      = win;
          state_d      = S_ISSUE;
          gnt_d[win]   = 1'b1;
          mem_wen_d    = win ? bus.r1_wen : bus.r0_wen;
          mem_ren_d    = win ? ~bus.r1_wen : ~bus.r0_wen;
          mem_addr_d   = win ? bus.r1_addr : bus.r0_addr;
          mem_wdata_d  = win ? bus.r1_wdata : bus.r0_wdata;
        end
      end

      S_ISSUE: begin
        last_d  = owner_q;
        cnt_d   = CW'(1);
        state_d = mem_wen_q ? S_IDLE : S_WAIT_RD;
      end

      S_WAIT_RD: begin
        if (bus.mem_rvalid) begin
          state_d           = S_IDLE;
          rvalid_d[owner_q] = 1'b1;
          if (owner_q) rdata1_d = bus.mem_rdata;
          else         rdata0_d = bus.mem_rdata;
        end else if (cnt_q == TMO) begin
          // Forced completion: owner still sees an rvalid, with zeroed data.
          state_d           = S_IDLE;
          rvalid_d[owner_q] = 1'b1;
          rd_err_d          = 1'b1;
          if (owner_q) rdata1_d = '0;
          else         rdata0_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      gnt_q       <= 2'b00;
      rvalid_q    <= 2'b00;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      mem_wen_q   <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_err_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      rvalid_q    <= rvalid_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      mem_wen_q   <= mem_wen_d;
      mem_ren_q   <= mem_ren_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_err_q    <= rd_err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.r0_gnt    = gnt_q[0];
  assign bus.r1_gnt    = gnt_q[1];
  assign bus.r0_rvalid = rvalid_q[0];
  assign bus.r1_rvalid = rvalid_q[1];
  assign bus.r0_rdata  = rdata0_q;
  assign bus.r1_rdata  = rdata1_q;
  assign bus.mem_wen   = mem_wen_q;
  assign bus.mem_ren   = mem_ren_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rd_err    = rd_err_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_bram_access_arbiter.sv
// tb/tb_bram_access_arbiter.sv - scoreboard bench for bram_access_arbiter
module tb_bram_access_arbiter;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int RR  = 1;
  localparam int TMO = 15;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  bram_access_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  bram_access_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RR_MODE(RR), .RD_TIMEOUT(TMO)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- requester stimulus ----------------
  bit              req_v   [2];
  bit              wen_v   [2];
  logic [AW-1:0]   addr_v  [2];
  logic [DW-1:0]   wdata_v [2];
  bit              en      [2];
  int              start_pct[2], hold_pct[2], drop_pct[2], rd_pct[2];
  int              done_cnt[2];

  assign bus.r0_req   = req_v[0];
  assign bus.r0_wen   = wen_v[0];
  assign bus.r0_addr  = addr_v[0];
  assign bus.r0_wdata = wdata_v[0];
  assign bus.r1_req   = req_v[1];
  assign bus.r1_wen   = wen_v[1];
  assign bus.r1_addr  = addr_v[1];
  assign bus.r1_wdata = wdata_v[1];

  task automatic new_txn(input int p);
    req_v[p]   = 1'b1;
    wen_v[p]   = (int'($urandom_range(0, 99)) >= rd_pct[p]);
    addr_v[p]  = AW'($urandom_range(0, 31));
    wdata_v[p] = DW'($urandom);
  endtask

  task automatic driver(input int p);
    logic g;
    forever begin
      @(posedge clk);
      #1;
      g = (p == 0) ? bus.r0_gnt : bus.r1_gnt;
      if (!rstn) begin
        req_v[p] = 1'b0;
      end else if (req_v[p] && g) begin
        done_cnt[p]++;
        if (en[p] && int'($urandom_range(0, 99)) < hold_pct[p]) new_txn(p);
        else req_v[p] = 1'b0;
      end else if (req_v[p]) begin
        if (int'($urandom_range(0, 99)) < drop_pct[p]) req_v[p] = 1'b0;
      end else if (en[p] && int'($urandom_range(0, 99)) < start_pct[p]) begin
        new_txn(p);
      end
    end
  endtask

  initial driver(0);
  initial driver(1);

  // ---------------- 1-cycle BRAM model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          mrv = 1'b0;
  logic [DW-1:0] mrd = '0;
  bit            drop = 1'b0;   // never answer reads
  bit            spur = 1'b0;   // random stray mem_rvalid pulses
  assign bus.mem_rvalid = mrv;
  assign bus.mem_rdata  = mrd;

  initial begin
    logic          ren, wen;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i * 7);
    forever begin
      @(posedge clk);
      ren = bus.mem_ren; wen = bus.mem_wen; a = bus.mem_addr; d = bus.mem_wdata;
      #1;
      mrv = (ren && !drop) || (spur && $urandom_range(0, 1) == 1);
      mrd = ren ? mem[a] : DW'($urandom);
      if (wen) mem[a] = d;
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct { int port; bit wen; logic [AW-1:0] addr; logic [DW-1:0] wdata; int at; } gexp_t;
  typedef struct { int port; logic [DW-1:0] data; bit err; int at; } rexp_t;
  gexp_t         gq[$];
  rexp_t         rq[$];
  logic [DW-1:0] shadow [0:(1<<AW)-1];
  int            free_at  = 0;   // first edge at which a new request can be taken
  int            dec_at   = 0;   // edge of the most recent grant decision
  int            last_srv = 1;

  initial begin
    int w;
    for (int i = 0; i < (1 << AW); i++) shadow[i] = DW'(i * 7);
    forever begin
      @(posedge clk);
      cyc++;
      if (!rstn) begin
        free_at = 0; dec_at = 0; last_srv = 1;
        gq.delete(); rq.delete();
      end else if (cyc >= free_at && (req_v[0] || req_v[1])) begin
        if (req_v[0] && req_v[1]) w = (RR != 0) ? (last_srv == 0 ? 1 : 0) : 0;
        else w = req_v[1] ? 1 : 0;
        gq.push_back('{port: w, wen: wen_v[w], addr: addr_v[w], wdata: wdata_v[w], at: cyc});
        last_srv = w;
        dec_at   = cyc;
        if (wen_v[w]) begin
          shadow[addr_v[w]] = wdata_v[w];
          free_at = cyc + 2;
        end else if (drop) begin
          rq.push_back('{port: w, data: '0, err: 1'b1, at: cyc + TMO + 1});
          free_at = cyc + TMO + 2;
        end else begin
          rq.push_back('{port: w, data: shadow[addr_v[w]], err: 1'b0, at: cyc + 2});
          free_at = cyc + 3;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int            rv_events = 0;
  int            g0_times[$];
  int            gseq[$];
  logic [DW-1:0] prev0 = '0, prev1 = '0;
  logic          prev_rstn = 1'b0;

  always @(negedge clk) begin
    gexp_t g;
    rexp_t r;
    logic  anyg, anyrv;
    anyg  = bus.r0_gnt | bus.r1_gnt;
    anyrv = bus.r0_rvalid | bus.r1_rvalid;
    chk("busy", bus.busy, (rstn && cyc >= dec_at && cyc < free_at - 1) ? 1 : 0);
    if (!rstn) begin
      chk("rst_ctrl", {bus.r0_gnt, bus.r1_gnt, bus.r0_rvalid, bus.r1_rvalid, bus.mem_wen, bus.mem_ren, bus.rd_err}, 0);
      chk("rst_data", {bus.r0_rdata, bus.r1_rdata, bus.mem_wdata}, 0);
      chk("rst_addr", bus.mem_addr, 0);
    end else begin
      if (bus.r0_gnt && bus.r1_gnt) chk("gnt_both", 1, 0);
      if (anyg) begin
        if (bus.r0_gnt) g0_times.push_back(cyc);
        gseq.push_back(bus.r1_gnt ? 1 : 0);
        if (gq.size() == 0) chk("gnt_expected", 0, 1);
        else begin
          g = gq.pop_front();
          chk("gnt_port", bus.r1_gnt, g.port);
          chk("gnt_cycle", cyc, g.at);
          chk("mem_wen", bus.mem_wen, g.wen);
          chk("mem_ren", bus.mem_ren, !g.wen);
          chk("mem_addr", bus.mem_addr, g.addr);
          if (g.wen) chk("mem_wdata", bus.mem_wdata, g.wdata);
        end
      end else begin
        chk("mem_en_no_gnt", {bus.mem_wen, bus.mem_ren}, 0);
        if (gq.size() != 0 && cyc > gq[0].at) begin
          chk("gnt_missing", 0, 1);
          void'(gq.pop_front());
        end
      end
      if (anyrv || bus.rd_err) rv_events++;
      if (bus.r0_rvalid && bus.r1_rvalid) chk("rvalid_both", 1, 0);
      if (anyrv) begin
        chk("rvalid_with_gnt", anyg, 0);
        if (rq.size() == 0) chk("rvalid_expected", 0, 1);
        else begin
          r = rq.pop_front();
          chk("rvalid_port", bus.r1_rvalid, r.port);
          chk("rvalid_cycle", cyc, r.at);
          chk("rdata", r.port ? bus.r1_rdata : bus.r0_rdata, r.data);
          chk("rd_err", bus.rd_err, r.err);
        end
      end else begin
        chk("rd_err_alone", bus.rd_err, 0);
        if (rq.size() != 0 && cyc > rq[0].at) begin
          chk("rvalid_missing", 0, 1);
          void'(rq.pop_front());
        end
      end
      if (prev_rstn) begin
        if (!bus.r0_rvalid) chk("r0_rdata_hold", bus.r0_rdata, prev0);
        if (!bus.r1_rvalid) chk("r1_rdata_hold", bus.r1_rdata, prev1);
      end
    end
    prev0     = bus.r0_rdata;
    prev1     = bus.r1_rdata;
    prev_rstn = rstn;
  end

  // ---------------- sequencing helpers ----------------
  function automatic bit model_idle();
    return !req_v[0] && !req_v[1] && cyc >= free_at && gq.size() == 0 && rq.size() == 0;
  endfunction

  task automatic wait_idle(input string nm);
    int k;
    k = 0;
    while (!model_idle() && k < 400) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk(nm, model_idle(), 1);
  endtask

  task automatic set_drv(input int p, input bit e, input int st, input int hd, input int dp, input int rd);
    en[p] = e; start_pct[p] = st; hold_pct[p] = hd; drop_pct[p] = dp; rd_pct[p] = rd;
  endtask

  task automatic one(input int p, input bit w, input int a, input int d);
    int   k;
    logic g;
    k = 0;
    @(posedge clk);
    #1;
    req_v[p] = 1'b1; wen_v[p] = w; addr_v[p] = AW'(a); wdata_v[p] = DW'(d);
    do begin
      @(posedge clk);
      #2;
      g = (p == 0) ? bus.r0_gnt : bus.r1_gnt;
      k++;
    end while (!g && k < 50);
    chk("directed_gnt_seen", g, 1);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: run did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int base, ev0, k;
    for (int p = 0; p < 2; p++) begin
      set_drv(p, 1'b0, 0, 0, 0, 0);
      addr_v[p] = '0; wdata_v[p] = '0;
    end
    #1 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;

    one(0, 1'b1, 'h010, 'hA5);
    wait_idle("idle_after_write");
    one(1, 1'b0, 'h010, 0);
    wait_idle("idle_after_read");
    chk("r1_rdata_a5", bus.r1_rdata, 'hA5);
    chk("r0_rdata_untouched", bus.r0_rdata, 0);

    one(0, 1'b0, 'h010, 0);
    wait_idle("idle_after_r0_read");
    chk("r0_rdata_a5", bus.r0_rdata, 'hA5);
    drop = 1'b1;
    ev0  = rv_events;
    one(0, 1'b0, 'h020, 0);
    wait_idle("idle_after_timeout");
    chk("timeout_rdata_zero", bus.r0_rdata, 0);
    chk("timeout_events", rv_events - ev0, 1);

    one(1, 1'b0, 'h033, 0);
    repeat (4) @(posedge clk);
    #2 rstn = 1'b0;
    ev0 = rv_events;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    drop = 1'b0;
    repeat (30) @(posedge clk);
    chk("no_rvalid_after_reset", rv_events - ev0, 0);
    wait_idle("idle_after_reset");

    g0_times.delete();
    base = done_cnt[0];
    set_drv(0, 1'b1, 100, 100, 0, 0);
    k = 0;
    while (done_cnt[0] - base < 8 && k < 200) begin
      @(posedge clk);
      k++;
    end
    set_drv(0, 1'b0, 0, 0, 0, 0);
    wait_idle("idle_after_b2b");
    chk("b2b_count", (g0_times.size() >= 8) ? 1 : 0, 1);
    if (g0_times.size() >= 8) chk("b2b_span", g0_times[7] - g0_times[0], 14);

    spur = 1'b1;
    gseq.delete();
    set_drv(0, 1'b1, 100, 100, 0, 0);
    set_drv(1, 1'b1, 100, 100, 0, 0);
    repeat (40) @(posedge clk);
    set_drv(0, 1'b0, 0, 0, 0, 0);
    set_drv(1, 1'b0, 0, 0, 0, 0);
    wait_idle("idle_after_contention");
    spur = 1'b0;
    chk("contention_grants", (gseq.size() >= 10) ? 1 : 0, 1);
    for (int i = 1; i < gseq.size(); i++) chk("rr_alternate", (gseq[i] != gseq[i-1]) ? 1 : 0, 1);

    set_drv(0, 1'b1, 40, 50, 10, 50);
    set_drv(1, 1'b1, 40, 50, 10, 50);
    repeat (1200) @(posedge clk);
    set_drv(0, 1'b0, 0, 0, 0, 0);
    set_drv(1, 1'b0, 0, 0, 0, 0);
    wait_idle("idle_after_random");

    drop = 1'b1;
    set_drv(0, 1'b1, 30, 50, 5, 70);
    set_drv(1, 1'b1, 30, 50, 5, 70);
    repeat (300) @(posedge clk);
    set_drv(0, 1'b0, 0, 0, 0, 0);
    set_drv(1, 1'b0, 0, 0, 0, 0);
    wait_idle("idle_after_random_timeout");
    drop = 1'b0;

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
